// File: rtl/reaction_timer_pkg.sv
// Shared definitions for the reaction timer core.
// Holds the trial state encoding, the LFSR feedback mask and the helpers
// that size the delay counter and advance the pseudo-random generator.
package reaction_timer_pkg;

  // One trial walks IDLE -> ARMED -> MEASURE -> RESULT. A react edge while
  // ARMED ends the trial in FOUL instead.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_RESULT  = 3'd3,
    ST_FOUL    = 3'd4
  } state_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  // Bits 15, 13, 12 and 10 of the shifted word receive the feedback.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // The delay counter must hold DELAY_MIN_MS + (2^span - 1), the largest
  // value that can be loaded.
  function automatic int delay_cnt_width(input int min_ms, input int span_log2);
    return $clog2(min_ms + (1 << span_log2));
  endfunction

  // Advance the LFSR by one step. A nonzero state never maps to zero.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD counter used for the reaction time result.
// Latency: one clock from clr/inc to the updated bcd value. No backpressure:
// inc is accepted every cycle it is high, and is ignored once every digit is 9.
// Ports:
//   clk_50MHz, rst_n : clock and asynchronous active-low reset
//   clr              : zero the count (wins over inc)
//   inc              : add one with decimal carry
//   bcd              : count, digit 0 in [3:0]
//   at_max           : every digit is 9; further increments are ignored
module bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_50MHz,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  at_max
);

  logic [4*DIGITS-1:0] bcd_nxt;
  logic                carry;
  logic                all_nines;

  // Ripple the carry from digit 0 upwards. A digit only advances when every
  // lower digit wrapped from 9 to 0 in this same update.
  always_comb begin
    bcd_nxt   = bcd;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_nxt[4*i +: 4] = 4'd0;
        end else begin
          bcd_nxt[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  assign at_max = all_nines;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      bcd <= '0;
    end else if (clr) begin
      bcd <= '0;
    end else if (inc && !all_nines) begin
      // Saturate at all-9s rather than wrapping back to zero.
      bcd <= bcd_nxt;
    end
  end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer control and measurement core: waits a pseudo-random delay
// after a start press, lights the stimulus LED, then counts milliseconds in
// BCD until the react press.
// Latency: every output is registered; a button edge or tick sampled on one
// clock edge is reflected on the outputs right after that edge.
// Backpressure: none. Ticks and button edges are consumed as they arrive;
// edges that mean nothing in the current state are dropped.
// Ports:
//   clk_50MHz, rst_n : system clock and asynchronous active-low reset
//   tick_1ms         : one-cycle pulse per millisecond from the divider
//   start_btn        : debounced start level; its rising edge starts a trial
//   react_btn        : debounced react level; its rising edge stops a trial
//   stim_led         : lit while measuring
//   bcd              : result, DIGITS BCD digits, digit 0 least significant
//   busy             : trial in progress (ARMED or MEASURE)
//   done             : trial finished with a valid time
//   false_start      : react pressed before the stimulus
//   overflow         : count saturated during this trial
module reaction_timer_core
  import reaction_timer_pkg::*;
#(
  parameter int          DIGITS          = 4,
  parameter int          DELAY_MIN_MS    = 1000,
  parameter int          DELAY_SPAN_LOG2 = 11,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                  clk_50MHz,
  input  logic                  rst_n,
  input  logic                  tick_1ms,
  input  logic                  start_btn,
  input  logic                  react_btn,
  output logic                  stim_led,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  false_start,
  output logic                  overflow
);

  localparam int DW = delay_cnt_width(DELAY_MIN_MS, DELAY_SPAN_LOG2);

  state_t         state;
  logic [DW-1:0]  delay;
  logic [DW-1:0]  delay_load;
  logic [15:0]    lfsr;
  logic           start_q;
  logic           react_q;
  logic           start_e;
  logic           react_e;
  logic           idle_like;
  logic           cnt_clr;
  logic           cnt_inc;
  logic           cnt_at_max;

  // Buttons arrive already synchronized and debounced; only the rising edge
  // carries meaning, so a held level never re-triggers anything.
  assign start_e = start_btn & ~start_q;
  assign react_e = react_btn & ~react_q;

  // States from which a start edge launches a new trial.
  assign idle_like = (state == ST_IDLE) || (state == ST_RESULT) || (state == ST_FOUL);

  // The random part of the delay is taken from the LFSR value present in the
  // very cycle the start edge is seen.
  assign delay_load = DW'(DELAY_MIN_MS) + DW'(lfsr[DELAY_SPAN_LOG2-1:0]);

  // Counter control. A react edge and a tick in the same cycle stop the
  // trial without counting that tick.
  assign cnt_clr = idle_like && start_e;
  assign cnt_inc = (state == ST_MEASURE) && tick_1ms && !react_e;

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_bcd_counter (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .bcd       (bcd),
    .at_max    (cnt_at_max)
  );

  // Single state machine. The status outputs are written together with the
  // state transition so they always agree with the registered state.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      delay       <= '0;
      start_q     <= 1'b0;
      react_q     <= 1'b0;
      lfsr        <= LFSR_SEED;
      stim_led    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      false_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      start_q <= start_btn;
      react_q <= react_btn;
      // Free-running so the delay depends on when the user presses start.
      lfsr    <= lfsr_advance(lfsr);

      case (state)
        ST_IDLE, ST_RESULT, ST_FOUL: begin
          if (start_e) begin
            state       <= ST_ARMED;
            delay       <= delay_load;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            false_start <= 1'b0;
            stim_led    <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (react_e) begin
            // Pressing before the stimulus is a foul, even with a tick
            // landing in the same cycle.
            state       <= ST_FOUL;
            busy        <= 1'b0;
            false_start <= 1'b1;
          end else if (tick_1ms) begin
            // A zero load can only occur with DELAY_MIN_MS = 0; treat it like
            // one remaining tick instead of wrapping the counter.
            if (delay == DW'(0) || delay == DW'(1)) begin
              delay    <= '0;
              state    <= ST_MEASURE;
              stim_led <= 1'b1;
            end else begin
              delay <= delay - DW'(1);
            end
          end
        end

        ST_MEASURE: begin
          if (react_e) begin
            state    <= ST_RESULT;
            stim_led <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (tick_1ms && cnt_at_max) begin
            // The count cannot grow any further: report a saturated result.
            state    <= ST_RESULT;
            stim_led <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          stim_led    <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          false_start <= 1'b0;
          overflow    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Randomized scoreboard bench for reaction_timer_core. Instance a uses four
// digits and instance b two digits; both use a short delay (3 + 0..3 ticks)
// and a tick every 4 clocks.
module tb_reaction_timer_core;

  logic        clk_50MHz;
  logic        rst_n;
  logic        tick_1ms;
  logic        start_a, react_a, start_b, react_b;
  logic        stim_a, busy_a, done_a, fs_a, ovf_a;
  logic        stim_b, busy_b, done_b, fs_b, ovf_b;
  logic [15:0] bcd_a;
  logic [7:0]  bcd_b;

  reaction_timer_core #(
    .DIGITS(4), .DELAY_MIN_MS(3), .DELAY_SPAN_LOG2(2), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .tick_1ms(tick_1ms),
    .start_btn(start_a), .react_btn(react_a), .stim_led(stim_a), .bcd(bcd_a),
    .busy(busy_a), .done(done_a), .false_start(fs_a), .overflow(ovf_a)
  );

  reaction_timer_core #(
    .DIGITS(2), .DELAY_MIN_MS(3), .DELAY_SPAN_LOG2(2), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .tick_1ms(tick_1ms),
    .start_btn(start_b), .react_btn(react_b), .stim_led(stim_b), .bcd(bcd_b),
    .busy(busy_b), .done(done_b), .false_start(fs_b), .overflow(ovf_b)
  );

  initial begin
    clk_50MHz = 1'b0;
    forever #5 clk_50MHz = ~clk_50MHz;
  end

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifted right, seed 0xACE1,
  // one step per clock while out of reset.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] poly_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction
  always @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= poly_step(m_lfsr);
  end

  // Decimal value of n in digs BCD digits, saturating at all nines.
  function automatic logic [31:0] to_bcd(input int n, input int digs);
    logic [31:0] r;
    int v, mx;
    mx = 1;
    for (int i = 0; i < digs; i++) mx = mx * 10;
    mx = mx - 1;
    v = (n > mx) ? mx : n;
    r = '0;
    for (int i = 0; i < digs; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] get_stim(input bit w); return w ? 32'(stim_b) : 32'(stim_a); endfunction
  function automatic logic [31:0] get_busy(input bit w); return w ? 32'(busy_b) : 32'(busy_a); endfunction
  function automatic logic [31:0] get_done(input bit w); return w ? 32'(done_b) : 32'(done_a); endfunction
  function automatic logic [31:0] get_fs(input bit w);   return w ? 32'(fs_b)   : 32'(fs_a);   endfunction
  function automatic logic [31:0] get_ovf(input bit w);  return w ? 32'(ovf_b)  : 32'(ovf_a);  endfunction
  function automatic logic [31:0] get_bcd(input bit w);  return w ? 32'(bcd_b)  : 32'(bcd_a);  endfunction

  // Scoreboard: one entry per trial outcome, pushed when the deciding input
  // is driven, popped when done or false_start rises.
  typedef struct { logic [31:0] done, fs, ovf, bcd; } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic push(input bit w, input logic [31:0] fs, input logic [31:0] ovf, input logic [31:0] bcd);
    exp_t e;
    e.done = (fs == 0) ? 32'd1 : 32'd0;
    e.fs   = fs;
    e.ovf  = ovf;
    e.bcd  = bcd;
    if (w) q_b.push_back(e);
    else   q_a.push_back(e);
  endtask

  task automatic sb_step(input bit w);
    exp_t e;
    logic now, was, empty;
    now   = w ? (done_b | fs_b) : (done_a | fs_a);
    was   = w ? prev_b : prev_a;
    empty = w ? (q_b.size() == 0) : (q_a.size() == 0);
    if (now && !was) begin
      if (empty) begin
        chk(w ? "sb_b_spurious_result" : "sb_a_spurious_result", 32'd1, 32'd0);
      end else begin
        if (w) e = q_b.pop_front();
        else   e = q_a.pop_front();
        chk(w ? "sb_b_done" : "sb_a_done", get_done(w), e.done);
        chk(w ? "sb_b_false_start" : "sb_a_false_start", get_fs(w), e.fs);
        chk(w ? "sb_b_overflow" : "sb_a_overflow", get_ovf(w), e.ovf);
        chk(w ? "sb_b_bcd" : "sb_a_bcd", get_bcd(w), e.bcd);
        chk(w ? "sb_b_stim_off" : "sb_a_stim_off", get_stim(w), 32'd0);
      end
    end
    if (w) prev_b = now;
    else   prev_a = now;
  endtask

  always @(negedge clk_50MHz) begin
    sb_step(1'b0);
    sb_step(1'b1);
  end

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_50MHz);
    #1;
    cyc++;
    tick_1ms = (cyc % 4 == 0);
  endtask

  task automatic set_btn(input bit w, input bit is_react, input logic v);
    if (w) begin
      if (is_react) react_b = v; else start_b = v;
    end else begin
      if (is_react) react_a = v; else start_a = v;
    end
  endtask

  // Start a trial and walk through ARMED. Either the stimulus must light one
  // clock after the d-th tick, or (foul) react is pressed after foul_after ticks.
  task automatic arm(input bit w, input int gap, input bit want2, input bit foul, input int foul_after);
    int d, counted;
    for (int i = 0; i < gap; i++) step();
    step();
    if (want2) begin
      for (int g = 0; g < 64 && m_lfsr[1:0] != 2'd2; g++) step();
    end
    set_btn(w, 1'b0, 1'b1);
    d = 3 + int'(m_lfsr[1:0]);
    step();
    set_btn(w, 1'b0, 1'b0);
    counted = 0;
    for (int g = 0; g < 200; g++) begin
      if (g == 0) begin
        chk("armed_entry_bcd", get_bcd(w), 32'd0);
        chk("armed_entry_false_start", get_fs(w), 32'd0);
        chk("armed_entry_done", get_done(w), 32'd0);
        chk("armed_entry_overflow", get_ovf(w), 32'd0);
      end
      if (foul && counted == foul_after && !tick_1ms) begin
        set_btn(w, 1'b1, 1'b1);
        push(w, 32'd1, 32'd0, 32'd0);
        break;
      end
      chk("armed_busy", get_busy(w), 32'd1);
      chk("armed_stim", get_stim(w), 32'd0);
      if (tick_1ms) counted++;
      if (!foul && counted == d) break;
      step();
    end
    step();
    if (foul) begin
      set_btn(w, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
        chk("foul_stim_stays_off", get_stim(w), 32'd0);
        chk("foul_busy", get_busy(w), 32'd0);
        chk("foul_flag", get_fs(w), 32'd1);
        step();
      end
    end else begin
      chk("stim_rise_after_delay", get_stim(w), 32'd1);
      chk("measure_busy_entry", get_busy(w), 32'd1);
    end
  endtask

  // In MEASURE: let n ticks be counted, then press react on a quiet cycle or
  // (same=1) on the cycle of the next tick, which must not be counted.
  task automatic measure(input bit w, input int n, input bit same, output logic [31:0] exp_bcd);
    int counted, digs;
    counted = 0;
    digs    = w ? 2 : 4;
    exp_bcd = '0;
    set_btn(w, 1'b1, 1'b0);
    for (int g = 0; g < 2000; g++) begin
      chk("measure_bcd_running", get_bcd(w), to_bcd(counted, digs));
      chk("measure_stim", get_stim(w), 32'd1);
      chk("measure_busy", get_busy(w), 32'd1);
      if (g > 0 && counted == n && (same ? tick_1ms : !tick_1ms)) begin
        set_btn(w, 1'b1, 1'b1);
        exp_bcd = to_bcd(n, digs);
        push(w, 32'd0, 32'd0, exp_bcd);
        break;
      end
      if (tick_1ms) counted++;
      step();
    end
    step();
    set_btn(w, 1'b1, 1'b0);
    step();
    chk("result_stim", get_stim(w), 32'd0);
    chk("result_done", get_done(w), 32'd1);
    chk("result_busy", get_busy(w), 32'd0);
    chk("result_bcd", get_bcd(w), exp_bcd);
  endtask

  initial begin
    logic [31:0] eb;
    int counted;
    rst_n = 1'b0; tick_1ms = 1'b0;
    start_a = 1'b0; react_a = 1'b0; start_b = 1'b0; react_b = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("reset_stim", get_stim(1'(w)), 32'd0);
      chk("reset_bcd", get_bcd(1'(w)), 32'd0);
      chk("reset_busy", get_busy(1'(w)), 32'd0);
      chk("reset_done", get_done(1'(w)), 32'd0);
      chk("reset_false_start", get_fs(1'(w)), 32'd0);
      chk("reset_overflow", get_ovf(1'(w)), 32'd0);
    end
    rst_n = 1'b1;

    // Delay 5 trial (LFSR low bits 2), 37 counted ticks, then frozen result.
    arm(1'b0, 2, 1'b1, 1'b0, 0);
    measure(1'b0, 37, 1'b0, eb);
    for (int i = 0; i < 12; i++) begin
      chk("frozen_bcd", get_bcd(1'b0), 32'h0037);
      chk("frozen_done", get_done(1'b0), 32'd1);
      step();
    end

    // React on the same clock as the 10th tick: only 9 are counted.
    arm(1'b0, 1, 1'b0, 1'b0, 0);
    measure(1'b0, 9, 1'b1, eb);

    // False start, then a clean trial restarting from FOUL.
    arm(1'b0, 3, 1'b0, 1'b1, 1);
    arm(1'b0, 0, 1'b0, 1'b0, 0);
    measure(1'b0, 12, 1'b0, eb);

    // Randomized trials.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        arm(1'b0, $urandom_range(0, 7), 1'b0, 1'b1, $urandom_range(0, 2));
      end else begin
        arm(1'b0, $urandom_range(0, 7), 1'b0, 1'b0, 0);
        measure(1'b0, $urandom_range(0, 120), 1'($urandom_range(0, 1)), eb);
      end
    end

    // Asynchronous reset in the middle of a measurement at bcd = 5.
    arm(1'b0, 1, 1'b0, 1'b0, 0);
    counted = 0;
    for (int g = 0; g < 200; g++) begin
      chk("pre_reset_bcd", get_bcd(1'b0), to_bcd(counted, 4));
      if (counted == 5 && !tick_1ms) break;
      if (tick_1ms) counted++;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_stim", get_stim(1'b0), 32'd0);
    chk("midreset_bcd", get_bcd(1'b0), 32'd0);
    chk("midreset_busy", get_busy(1'b0), 32'd0);
    chk("midreset_done", get_done(1'b0), 32'd0);
    chk("midreset_false_start", get_fs(1'b0), 32'd0);
    chk("midreset_overflow", get_ovf(1'b0), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    // Delay timing of this trial relies on the LFSR restarting from its seed.
    arm(1'b0, 0, 1'b0, 1'b0, 0);
    measure(1'b0, 4, 1'b0, eb);

    // Two-digit instance: saturation and overflow on the 100th tick.
    arm(1'b1, 0, 1'b0, 1'b0, 0);
    counted = 0;
    for (int g = 0; g < 1000; g++) begin
      chk("sat_bcd_running", get_bcd(1'b1), to_bcd(counted, 2));
      chk("sat_overflow_low", get_ovf(1'b1), 32'd0);
      chk("sat_done_low", get_done(1'b1), 32'd0);
      if (tick_1ms) begin
        counted++;
        if (counted == 100) begin
          push(1'b1, 32'd0, 32'd1, 32'h99);
          break;
        end
      end
      step();
    end
    step();
    step();
    chk("sat_done", get_done(1'b1), 32'd1);
    chk("sat_overflow", get_ovf(1'b1), 32'd1);
    chk("sat_bcd", get_bcd(1'b1), 32'h99);
    chk("sat_stim", get_stim(1'b1), 32'd0);

    // A held react level must not act: neither in RESULT nor once re-armed.
    react_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("held_react_done", get_done(1'b1), 32'd1);
      chk("held_react_bcd", get_bcd(1'b1), 32'h99);
    end
    arm(1'b1, 0, 1'b0, 1'b0, 0);
    measure(1'b1, 3, 1'b0, eb);

    repeat (4) step();
    chk("scoreboard_a_drained", 32'(q_a.size()), 32'd0);
    chk("scoreboard_b_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
